// File: rtl/keypad_scan_ctrl.sv
// Row-strobed 5x4 keypad scanner with debounced press/release detection.
// Reports the row/column pair of a stable single keypress with a one-clock valid pulse.
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] col_in,
    output logic [4:0] row_drive,
    output logic [4:0] key_row,
    output logic [3:0] key_col,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT);

    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] PRESSED  = 2'd2;
    localparam logic [1:0] RELEASE  = 2'd3;

    logic [3:0]    col_m;
    logic [3:0]    col_s;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          single_zero;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] dcnt_nxt;
    logic [DW-1:0] dcnt_inc;
    logic [3:0]    cand_col;
    logic          cand_load;
    logic          advance;
    logic          accept;
    logic          release_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_m <= '1;
            col_s <= '1;
        end else begin
            col_m <= col_in;
            col_s <= col_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (en) begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
        end
    end

    assign tick = en && (tick_cnt == TICK_LAST);

    always_comb begin
        case (col_s)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: single_zero = 1'b1;
            default:                            single_zero = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        dcnt_nxt     = dcnt;
        dcnt_inc     = dcnt + DW'(1);
        cand_load    = 1'b0;
        advance      = 1'b0;
        accept       = 1'b0;
        release_done = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (single_zero) begin
                        cand_load = 1'b1;
                        dcnt_nxt  = DW'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            accept    = 1'b1;
                            state_nxt = PRESSED;
                        end else begin
                            state_nxt = DEBOUNCE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (col_s == cand_col) begin
                        dcnt_nxt = dcnt_inc;
                        if (dcnt_inc == DB_LAST) begin
                            accept    = 1'b1;
                            state_nxt = PRESSED;
                        end
                    end else begin
                        advance   = 1'b1;
                        state_nxt = SCAN;
                    end
                end
                PRESSED: begin
                    if (col_s == 4'b1111) begin
                        dcnt_nxt = DW'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            release_done = 1'b1;
                            advance      = 1'b1;
                            state_nxt    = SCAN;
                        end else begin
                            state_nxt = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (col_s == 4'b1111) begin
                        dcnt_nxt = dcnt_inc;
                        if (dcnt_inc == DB_LAST) begin
                            release_done = 1'b1;
                            advance      = 1'b1;
                            state_nxt    = SCAN;
                        end
                    end else begin
                        state_nxt = PRESSED;
                    end
                end
                default: state_nxt = SCAN;
            endcase
        end
    end

    // row_drive is frozen outside SCAN and col_s matches the candidate on
    // acceptance, so the live row/column equal the latched candidate there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            dcnt      <= '0;
            cand_col  <= '0;
            row_drive <= 5'b00001;
            key_row   <= '0;
            key_col   <= '1;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nxt;
            dcnt      <= dcnt_nxt;
            key_valid <= accept;
            if (cand_load) begin
                cand_col <= col_s;
            end
            if (advance) begin
                row_drive <= {row_drive[3:0], row_drive[4]};
            end
            if (accept) begin
                key_row  <= row_drive;
                key_col  <= col_s;
                key_held <= 1'b1;
            end else if (release_done) begin
                key_held <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: a keypad model drives col_in from
// row_drive and a tick-level behavioural model predicts every output each clock.
module tb_keypad_scan_ctrl;

    localparam int unsigned SD = 4;
    localparam int unsigned DB = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] col_in;
    logic [4:0] row_drive;
    logic [4:0] key_row;
    logic [3:0] key_col;
    logic       key_valid;
    logic       key_held;

    logic       k_on = 1'b0;
    logic [4:0] k_row = 5'b00000;
    logic [3:0] k_col = 4'b1111;

    int ncmp = 0;
    int nerr = 0;

    keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .col_in    (col_in),
        .row_drive (row_drive),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    assign col_in = (k_on && row_drive == k_row) ? k_col : 4'b1111;

    // Reference model: row index, tick phase, run lengths of stable samples.
    int         m_idx, m_tcnt, m_run, m_rel;
    bit         m_holding, m_valid;
    logic [3:0] m_s1, m_s2, m_cand, m_kcol;
    logic [4:0] m_krow;

    function automatic logic [4:0] m_rowvec();
        return 5'(1 << m_idx);
    endfunction

    function automatic logic [15:0] mpack();
        return {m_rowvec(), m_krow, m_kcol, m_valid, m_holding};
    endfunction

    function automatic logic [15:0] dpack();
        return {row_drive, key_row, key_col, key_valid, key_held};
    endfunction

    task automatic model_reset();
        m_idx = 0; m_tcnt = 0; m_run = 0; m_rel = 0;
        m_holding = 0; m_valid = 0;
        m_s1 = 4'hF; m_s2 = 4'hF; m_cand = 4'h0;
        m_kcol = 4'hF; m_krow = 5'b00000;
    endtask

    task automatic model_update();
        logic [3:0] s;
        logic [3:0] pin;
        bit tick;
        pin = (k_on && m_rowvec() == k_row) ? k_col : 4'hF;
        s = m_s2;
        m_s2 = m_s1;
        m_s1 = pin;
        m_valid = 0;
        tick = en && (m_tcnt == SD - 1);
        if (en) m_tcnt = (m_tcnt + 1) % SD;
        if (!tick) return;
        if (!m_holding) begin
            if (m_run == 0) begin
                if ($countones(~s) == 1) begin
                    m_cand = s;
                    m_run = 1;
                end else begin
                    m_idx = (m_idx + 1) % 5;
                end
            end else if (s == m_cand) begin
                m_run = m_run + 1;
            end else begin
                m_run = 0;
                m_idx = (m_idx + 1) % 5;
            end
            if (m_run == DB) begin
                m_holding = 1; m_valid = 1; m_run = 0; m_rel = 0;
                m_krow = m_rowvec(); m_kcol = m_cand;
            end
        end else if (s == 4'hF) begin
            m_rel = m_rel + 1;
            if (m_rel == DB) begin
                m_holding = 0; m_rel = 0;
                m_idx = (m_idx + 1) % 5;
            end
        end else begin
            m_rel = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; k_on = 1'b0;
        model_reset();
        #12;
        ncmp++;
        if (dpack() !== 16'b00001_00000_1111_0_0) begin
            nerr++; $display("FAIL reset_values: got %b want %b", dpack(), 16'b00001_00000_1111_0_0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            ncmp++;
            if (dpack() !== mpack()) begin
                nerr++; $display("FAIL reset_scan cyc %0d: got %b want %b", i, dpack(), mpack());
            end
        end
        ncmp++;
        if (row_drive !== 5'b00001) begin
            nerr++; $display("FAIL reset_wrap: got %b want 00001", row_drive);
        end
    endtask

    task automatic test_hold_key();
        int nvalid = 0;
        bit done = 0;
        for (int i = 0; i < 40 && row_drive !== 5'b00001; i++) step();
        k_row = 5'b00010; k_col = 4'b1101; k_on = 1'b1;
        for (int i = 0; i < 160; i++) begin
            step();
            if (key_valid) nvalid++;
            ncmp++;
            if (dpack() !== mpack()) begin
                nerr++; $display("FAIL hold_track cyc %0d: got %b want %b", i, dpack(), mpack());
            end
        end
        ncmp++;
        if (nvalid != 1 || key_row !== 5'b00010 || key_col !== 4'b1101 || key_held !== 1'b1) begin
            nerr++; $display("FAIL hold_accept: pulses %0d row %b col %b held %b want 1 00010 1101 1",
                             nvalid, key_row, key_col, key_held);
        end
        k_on = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            ncmp++;
            if (dpack() !== mpack()) begin
                nerr++; $display("FAIL hold_release cyc %0d: got %b want %b", i, dpack(), mpack());
            end
            if (!key_held) done = 1;
        end
        ncmp++;
        if (!done || row_drive !== 5'b00100) begin
            nerr++; $display("FAIL hold_resume: cleared %0d row %b want 1 00100", done, row_drive);
        end
    endtask

    task automatic test_bounce();
        int nvalid = 0;
        logic [3:0] pats [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int i = 0; i < 40 && row_drive !== 5'b00100; i++) step();
        k_row = 5'b00100; k_col = pats[$urandom_range(0, 3)]; k_on = 1'b1;
        for (int i = 0; i < 44; i++) begin
            if (i == 4) k_on = 1'b0;
            step();
            if (key_valid) nvalid++;
            ncmp++;
            if (dpack() !== mpack()) begin
                nerr++; $display("FAIL bounce_track cyc %0d: got %b want %b", i, dpack(), mpack());
            end
        end
        ncmp++;
        if (nvalid != 0 || key_held !== 1'b0) begin
            nerr++; $display("FAIL bounce_ignored: pulses %0d held %b want 0 0", nvalid, key_held);
        end
    endtask

    task automatic test_two_keys();
        int nvalid = 0;
        bit done = 0;
        k_row = 5'b00010; k_col = 4'b1001; k_on = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (key_valid) nvalid++;
            ncmp++;
            if (dpack() !== mpack()) begin
                nerr++; $display("FAIL two_track cyc %0d: got %b want %b", i, dpack(), mpack());
            end
        end
        ncmp++;
        if (nvalid != 0) begin
            nerr++; $display("FAIL two_rejected: pulses %0d want 0", nvalid);
        end
        k_row = 5'b10000; k_col = 4'b0111;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            if (key_valid) done = 1;
        end
        ncmp++;
        if (!done || key_row !== 5'b10000 || key_col !== 4'b0111) begin
            nerr++; $display("FAIL single_after_two: seen %0d row %b col %b want 1 10000 0111", done, key_row, key_col);
        end
        k_on = 1'b0;
        for (int i = 0; i < 60 && key_held; i++) step();
    endtask

    task automatic test_release_bounce();
        int nvalid = 0;
        bit done = 0;
        k_row = 5'b00010; k_col = 4'b1101; k_on = 1'b1;
        for (int i = 0; i < 200 && !key_held; i++) begin
            step();
            if (key_valid) nvalid++;
        end
        for (int i = 0; i < 20; i++) begin
            if (i == 8) k_on = 1'b0;
            if (i == 12) k_on = 1'b1;
            step();
            if (key_valid) nvalid++;
            ncmp++;
            if (dpack() !== mpack() || key_held !== 1'b1) begin
                nerr++; $display("FAIL rel_bounce_hold cyc %0d: got %b want %b", i, dpack(), mpack());
            end
        end
        k_on = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            step();
            if (key_valid) nvalid++;
            if (!key_held) done = 1;
        end
        ncmp++;
        if (!done || nvalid != 1) begin
            nerr++; $display("FAIL rel_bounce_clear: cleared %0d pulses %0d want 1 1", done, nvalid);
        end
    endtask

    task automatic test_reset_pressed();
        bit done = 0;
        k_row = 5'b00010; k_col = 4'b1011; k_on = 1'b1;
        for (int i = 0; i < 200 && !key_held; i++) step();
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        ncmp++;
        if (dpack() !== 16'b00001_00000_1111_0_0) begin
            nerr++; $display("FAIL midreset_values: got %b want %b", dpack(), 16'b00001_00000_1111_0_0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            ncmp++;
            if (dpack() !== mpack()) begin
                nerr++; $display("FAIL midreset_track cyc %0d: got %b want %b", i, dpack(), mpack());
            end
            if (key_valid) done = 1;
        end
        ncmp++;
        if (!done || key_row !== 5'b00010 || key_col !== 4'b1011) begin
            nerr++; $display("FAIL midreset_redetect: seen %0d row %b col %b want 1 00010 1011", done, key_row, key_col);
        end
        k_on = 1'b0;
        for (int i = 0; i < 60 && key_held; i++) step();
    endtask

    task automatic test_en_freeze();
        logic [4:0] row_snap;
        int waited = 0;
        bit done = 0;
        k_row = 5'b01000; k_col = 4'b0111; k_on = 1'b1;
        for (int i = 0; i < 100 && !(m_run == 1 && !m_holding); i++) step();
        en = 1'b0;
        row_snap = row_drive;
        for (int i = 0; i < 20; i++) begin
            step();
            ncmp++;
            if (row_drive !== row_snap || key_valid !== 1'b0 || key_held !== 1'b0 || dpack() !== mpack()) begin
                nerr++; $display("FAIL en_freeze cyc %0d: got %b want row %b valid 0 held 0", i, dpack(), row_snap);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            waited++;
            if (key_valid) done = 1;
        end
        ncmp++;
        if (!done || waited != 8 || key_row !== 5'b01000 || key_col !== 4'b0111) begin
            nerr++; $display("FAIL en_resume: seen %0d after %0d clk row %b col %b want 1 8 01000 0111",
                             done, waited, key_row, key_col);
        end
        k_on = 1'b0;
        for (int i = 0; i < 60 && key_held; i++) step();
    endtask

    task automatic test_random();
        logic [3:0] pats [6] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1001, 4'b1111};
        int seg = 0;
        for (int i = 0; i < 1500; i++) begin
            if (seg == 0) begin
                seg = $urandom_range(1, 60);
                k_on = ($urandom_range(0, 3) != 0);
                k_row = 5'(1 << $urandom_range(0, 4));
                k_col = pats[$urandom_range(0, 5)];
            end
            seg--;
            if ($urandom_range(0, 19) == 0) en = ~en;
            step();
            ncmp++;
            if (dpack() !== mpack()) begin
                nerr++; $display("FAIL random cyc %0d: got %b want %b", i, dpack(), mpack());
            end
        end
        en = 1'b1;
        k_on = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hold_key();
        test_bounce();
        test_two_keys();
        test_release_bounce();
        test_reset_pressed();
        test_en_freeze();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
